// File: rtl/divider.sv
// Iterative radix-2 restoring divider for the Mini-MIPS execute stage.
// DIV/DIVU write quotient to LO and remainder to HI; MFLO/MFHI read them back on out.
// Optional build macro: DIVIDER_FAST_ZERO_EN -- a zero divisor is detected at accept
// and the forced result is written after a single cycle instead of the full sequence.
module divider #(
  parameter int         BUS_WIDTH = 32,
  parameter logic [2:0] DIV       = 3'b000,
  parameter logic [2:0] DIVU      = 3'b001,
  parameter logic [2:0] MFLO      = 3'b100,
  parameter logic [2:0] MFHI      = 3'b101
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  input  logic [2:0]           div_op,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] out
);

  localparam int W  = BUS_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [W-1:0]  divisor;
  logic [W-1:0]  dividend;
  logic          sign_q;
  logic          sign_r;
  logic          zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  logic          accept;
  logic          is_signed;
  logic [W-1:0]  abs1;
  logic [W-1:0]  abs2;
  logic [W:0]    shifted;
  logic          fits;
  logic [W-1:0]  sub;
  logic [W-1:0]  rem_step;
  logic [W-1:0]  quo_step;
  logic [W-1:0]  q_fix;
  logic [W-1:0]  r_fix;

  // Operand conditioning at accept and one restoring step on the current remainder:quotient.
  always_comb begin
    is_signed = (div_op == DIV);
    accept    = start && (state == IDLE) && ((div_op == DIV) || (div_op == DIVU));
    abs1      = (is_signed && in1[W-1]) ? -in1 : in1;
    abs2      = (is_signed && in2[W-1]) ? -in2 : in2;
    shifted   = {rem, quo[W-1]};
    fits      = (shifted >= {1'b0, divisor});
    // When the trial subtraction fits, the true difference is below 2^W, so W bits suffice.
    sub       = shifted[W-1:0] - divisor;
    rem_step  = fits ? sub : shifted[W-1:0];
    quo_step  = {quo[W-2:0], fits};
    q_fix     = sign_q ? -quo : quo;
    r_fix     = sign_r ? -rem : rem;
  end

  // Control FSM, datapath registers and the architectural HI/LO pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      dividend <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      zero     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rem      <= '0;
            quo      <= abs1;
            divisor  <= abs2;
            dividend <= in1;
            sign_q   <= is_signed && (in1[W-1] ^ in2[W-1]);
            sign_r   <= is_signed && in1[W-1];
            zero     <= (in2 == '0);
            count    <= '0;
            busy     <= 1'b1;
`ifdef DIVIDER_FAST_ZERO_EN
            state    <= (in2 == '0) ? FIX : RUN;
`else
            state    <= RUN;
`endif
          end
        end
        RUN: begin
          rem   <= rem_step;
          quo   <= quo_step;
          count <= count + CW'(1);
          if (count == CW'(W - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          // A zero divisor is not trapped: HI keeps the raw dividend, LO is all ones.
          if (zero) begin
            lo <= '1;
            hi <= dividend;
          end else begin
            lo <= q_fix;
            hi <= r_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-back mux for MFHI/MFLO; every other opcode drives zero.
  always_comb begin
    out = '0;
    if (div_op == MFHI) begin
      out = hi;
    end else if (div_op == MFLO) begin
      out = lo;
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed testbench for divider: scoreboard of expected HI/LO/latency, checked on done.
module tb_divider;

  localparam int W = 32;
  localparam logic [2:0] OP_DIV  = 3'b000;
  localparam logic [2:0] OP_DIVU = 3'b001;
  localparam logic [2:0] OP_MFLO = 3'b100;
  localparam logic [2:0] OP_MFHI = 3'b101;
  localparam logic [2:0] OP_NOP  = 3'b111;
`ifdef DIVIDER_FAST_ZERO_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = W + 1;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [2:0]   div_op;
  logic         start;
  logic         busy;
  logic         done;
  logic [W-1:0] out;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] prev_hi = '0;
  logic [W-1:0] prev_lo = '0;

  divider dut (
    .clk    (clk),
    .rst    (rst),
    .in1    (in1),
    .in2    (in2),
    .div_op (div_op),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the language's own division operators.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb_v;
    sa = a;
    sb_v = b;
    e.lat = W + 1;
    if (b == '0) begin
      e.hi = a;
      e.lo = '1;
      e.lat = ZERO_LAT;
    end else if (op == OP_DIVU) begin
      e.lo = a / b;
      e.hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = '0;
    end else begin
      e.lo = sa / sb_v;
      e.hi = sa % sb_v;
    end
    return e;
  endfunction

  // Called at a negedge; the start is accepted on the following posedge.
  task automatic start_div(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in1 = a;
    in2 = b;
    div_op = op;
    start = 1'b1;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", W'(busy), W'(1));
    chk("done_after_accept", W'(done), W'(0));
  endtask

  // Waits for done (bounded), checks latency, HI/LO via out; returns inside the done cycle.
  task automatic wait_result(input string tag, input int elapsed);
    exp_t e;
    int lat;
    lat = elapsed;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, W'(lat), W'(e.lat));
    chk({tag, "_busy_low"}, W'(busy), W'(0));
    div_op = OP_MFLO;
    #1;
    chk({tag, "_lo"}, out, e.lo);
    div_op = OP_MFHI;
    #1;
    chk({tag, "_hi"}, out, e.hi);
    prev_hi = e.hi;
    prev_lo = e.lo;
    $display("div %s: lo=%h hi=%h latency=%0d", tag, e.lo, e.hi, lat);
  endtask

  initial begin
    int done_seen;
    logic [W-1:0] a;
    logic [W-1:0] b;

    rst = 1'b1;
    start = 1'b0;
    in1 = '0;
    in2 = '0;
    div_op = OP_NOP;
    repeat (2) @(negedge clk);
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));
    div_op = OP_MFLO;
    #1;
    chk("reset_lo", out, '0);
    div_op = OP_MFHI;
    #1;
    chk("reset_hi", out, '0);
    rst = 1'b0;

    // Non-divide opcodes with start are ignored; other opcodes read zero.
    div_op = OP_NOP;
    start = 1'b1;
    in1 = 32'd10;
    in2 = 32'd2;
    #1;
    chk("nop_out_zero", out, '0);
    @(negedge clk);
    chk("nop_start_ignored", W'(busy), W'(0));
    div_op = OP_MFHI;
    @(negedge clk);
    start = 1'b0;
    chk("mfhi_start_ignored", W'(busy), W'(0));

    start_div(OP_DIVU, 32'd100, 32'd7);
    wait_result("divu_100_7", 0);
    chk("const_lo_14", prev_lo, 32'd14);
    chk("const_hi_2", prev_hi, 32'd2);

    // Back-to-back: each start is accepted on the edge ending the done cycle.
    start_div(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_result("div_m7_2", 0);
    chk("const_lo_m3", prev_lo, 32'hFFFF_FFFD);
    chk("const_hi_m1", prev_hi, 32'hFFFF_FFFF);
    start_div(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_result("div_7_m2", 0);
    chk("const_hi_1", prev_hi, 32'd1);
    start_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("div_overflow", 0);
    start_div(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("divu_big", 0);
    start_div(OP_DIVU, 32'h1234, 32'd0);
    wait_result("divu_by_zero", 0);
    chk("const_zero_lo", prev_lo, 32'hFFFF_FFFF);
    start_div(OP_DIV, 32'hFFFF_FFFB, 32'd0);
    wait_result("div_by_zero", 0);
    @(negedge clk);
    chk("done_single_pulse", W'(done), W'(0));

    // Start while busy is ignored; MFLO mid-run returns the previous LO.
    start_div(OP_DIVU, 32'd9, 32'd3);
    repeat (4) @(negedge clk);
    in1 = 32'd50;
    in2 = 32'd5;
    div_op = OP_DIVU;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    div_op = OP_MFLO;
    #1;
    chk("mflo_during_busy", out, prev_lo);
    chk("busy_mid_run", W'(busy), W'(1));
    wait_result("divu_9_3", 5);

    // Reset in the middle of a run discards the result.
    @(negedge clk);
    start_div(OP_DIVU, 32'd1000, 32'd3);
    void'(sb.pop_back());
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", W'(busy), W'(0));
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("rst_no_done", W'(done_seen), W'(0));
    div_op = OP_MFLO;
    #1;
    chk("rst_lo_cleared", out, '0);
    div_op = OP_MFHI;
    #1;
    chk("rst_hi_cleared", out, '0);
    @(negedge clk);
    start_div(OP_DIVU, 32'd77, 32'd8);
    wait_result("after_reset", 0);

    // A few random operand pairs for both opcodes.
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? W'($urandom_range(1, 5000)) : $urandom;
      if (b[W-1] && (i % 3 == 0)) b = -b;
      start_div((i % 2 == 0) ? OP_DIV : OP_DIVU, a, b);
      wait_result((i % 2 == 0) ? "rand_div" : "rand_divu", 0);
    end

    @(negedge clk);
    chk("scoreboard_empty", W'(sb.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
